// File: rtl/key_sched_if.sv
// Control and round-key read bundle between the key scheduler
// and the cipher cores that start it and read its key store.
interface key_sched_if #(
  parameter int KW = 128
);
  logic          start;
  logic          clear;
  logic [0:KW-1] key_in;
  logic          busy;
  logic          done;
  logic          keys_valid;
  logic [3:0]    rd_idx;
  logic [0:KW-1] rd_key;

  modport master (
    output start, clear, key_in, rd_idx,
    input  busy, done, keys_valid, rd_key
  );

  modport slave (
    input  start, clear, key_in, rd_idx,
    output busy, done, keys_valid, rd_key
  );
endinterface

// File: rtl/key_sched_ctrl.sv
// AES-128 key expansion sequencer: drives a combinational key_gen
// round one round per clock and stores rk0..rkNR for indexed reads.
module key_sched_ctrl #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic          clk,
  input  logic          rst,
  key_sched_if.slave    sif,
  output logic [0:KW-1] o_kg_temp_key,
  output logic [0:KW-1] o_kg_mx_key,
  output logic [0:31]   o_kg_rcon,
  input  logic [0:KW-1] i_kg_r_key
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(NR);

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_round;
  logic [0:KW-1] r_cur;
  logic          r_kv;
  logic [0:KW-1] r_rd_key;
  logic [0:KW-1] r_store [0:NR];
  logic          w_exp;

  function automatic logic [7:0] f_rc(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    unique case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (sif.start) w_next = S_EXPAND;
      S_EXPAND: if (r_round == LAST) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (sif.clear) w_next = S_IDLE;
  end

  assign w_exp          = (r_state == S_EXPAND);
  assign sif.busy       = (r_state != S_IDLE);
  assign sif.done       = (r_state == S_DONE);
  assign sif.keys_valid = r_kv;
  assign sif.rd_key     = r_rd_key;
  assign o_kg_temp_key  = w_exp ? r_cur : '0;
  assign o_kg_rcon      = w_exp ? {f_rc(r_round), 24'h0} : '0;
  assign o_kg_mx_key    = '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_round <= '0;
      r_cur   <= '0;
      r_kv    <= 1'b0;
      for (int i = 0; i <= NR; i++) r_store[i] <= '0;
    end else begin
      r_state <= w_next;
      // Abort leaves the store untouched; only validity is dropped.
      if (sif.clear) begin
        r_round <= '0;
        r_kv    <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (sif.start) begin
              r_store[0] <= sif.key_in;
              r_cur      <= sif.key_in;
              r_round    <= 4'd1;
              r_kv       <= 1'b0;
            end
          end
          S_EXPAND: begin
            r_store[r_round] <= i_kg_r_key;
            r_cur            <= i_kg_r_key;
            if (r_round == LAST) r_kv <= 1'b1;
            else r_round <= r_round + 4'd1;
          end
          S_DONE:  r_round <= '0;
          default: r_round <= '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rd_key <= '0;
    else if (sif.rd_idx <= LAST) r_rd_key <= r_store[sif.rd_idx];
    else r_rd_key <= '0;
  end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Directed bench for key_sched_ctrl with a behavioural key_gen round
// and FIPS-197 reference round keys.
module tb_key_sched_ctrl;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] exp;
  } rd_vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_sched_if #(.KW(128)) sif ();

  logic [127:0] kg_temp;
  logic [127:0] kg_mx;
  logic [127:0] kg_rk;
  logic [31:0]  kg_rcon;

  key_sched_ctrl #(.NR(10), .KW(128)) dut (
    .clk           (clk),
    .rst           (rst),
    .sif           (sif),
    .o_kg_temp_key (kg_temp),
    .o_kg_mx_key   (kg_mx),
    .o_kg_rcon     (kg_rcon),
    .i_kg_r_key    (kg_rk)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0]  rc_tab [0:10];
  logic [127:0] exp_rk [0:10];

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K3 = 128'h000102030405060708090a0b0c0d0e0f;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] e;
    r = 8'h01;
    e = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (e[i]) r = gmul(r, a);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] kexp(input logic [127:0] k, input logic [31:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ rc;
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  always_comb kg_rk = kexp(kg_temp, kg_rcon);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic build(input logic [127:0] key);
    exp_rk[0] = key;
    for (int r = 1; r <= 10; r++) exp_rk[r] = kexp(exp_rk[r-1], rc_tab[r]);
  endtask

  task automatic expand(input logic [127:0] key, input bit repulse);
    int dones;
    dones = 0;
    build(key);
    sif.key_in = key;
    sif.start  = 1'b1;
    tick();
    sif.start = 1'b0;
    chk("kv_drop", sif.keys_valid, 0);
    for (int k = 1; k <= 10; k++) begin
      chk("busy_exp", sif.busy, 1);
      chk("rcon", kg_rcon, rc_tab[k]);
      chk("mx_zero", kg_mx, 0);
      chk("temp_key", kg_temp, exp_rk[k-1]);
      if (sif.done) dones++;
      sif.start = repulse && (k == 3 || k == 7);
      if (sif.start) sif.key_in = ~key;
      tick();
    end
    sif.start = 1'b0;
    if (sif.done) dones++;
    chk("done_busy", sif.busy, 1);
    chk("done_kv", sif.keys_valid, 1);
    chk("done_rcon", kg_rcon, 0);
    tick();
    if (sif.done) dones++;
    chk("idle_busy", sif.busy, 0);
    chk("idle_kv", sif.keys_valid, 1);
    chk("done_count", dones, 1);
  endtask

  task automatic sweep();
    rd_vec_t vec [16];
    for (int i = 0; i < 16; i++) begin
      vec[i].idx = 4'(i);
      vec[i].exp = (i <= 10) ? exp_rk[i] : '0;
    end
    for (int i = 0; i < 16; i++) begin
      sif.rd_idx = vec[i].idx;
      tick();
      chk($sformatf("sweep_%0d", i), sif.rd_key, vec[i].exp);
    end
  endtask

  task automatic rdchk(input string nm, input logic [3:0] idx, input logic [127:0] exp);
    sif.rd_idx = idx;
    tick();
    chk(nm, sif.rd_key, exp);
  endtask

  initial begin
    rc_tab = '{32'h0, 32'h01000000, 32'h02000000, 32'h04000000, 32'h08000000,
               32'h10000000, 32'h20000000, 32'h40000000, 32'h80000000,
               32'h1b000000, 32'h36000000};
    rst        = 1'b1;
    sif.start  = 1'b0;
    sif.clear  = 1'b0;
    sif.key_in = '0;
    sif.rd_idx = '0;
    #12;
    chk("rst_busy", sif.busy, 0);
    chk("rst_done", sif.done, 0);
    chk("rst_kv", sif.keys_valid, 0);
    chk("rst_rdkey", sif.rd_key, 0);
    chk("rst_temp", kg_temp, 0);
    chk("rst_rcon", kg_rcon, 0);
    chk("rst_mx", kg_mx, 0);
    rst = 1'b0;
    tick();

    expand(K1, 1'b0);
    sweep();
    rdchk("fips_rk0", 4'd0, K1);
    rdchk("fips_rk1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
    rdchk("fips_rk10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    expand('0, 1'b0);
    rdchk("zero_rk1", 4'd1, 128'h62636363626363636263636362636363);

    expand(K1, 1'b1);
    sweep();
    rdchk("repulse_rk10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    sif.key_in = K3;
    sif.start  = 1'b1;
    tick();
    sif.start = 1'b0;
    repeat (4) tick();
    sif.clear = 1'b1;
    tick();
    sif.clear = 1'b0;
    chk("clr_busy", sif.busy, 0);
    chk("clr_kv", sif.keys_valid, 0);
    chk("clr_done", sif.done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("clr_nodone", sif.done, 0);
    end

    expand(K3, 1'b0);
    sweep();
    rdchk("k3_rk10", 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    sif.clear = 1'b1;
    sif.start = 1'b1;
    tick();
    sif.clear = 1'b0;
    sif.start = 1'b0;
    chk("cs_busy", sif.busy, 0);
    chk("cs_kv", sif.keys_valid, 0);
    tick();
    chk("cs_busy2", sif.busy, 0);

    sif.rd_idx = 4'd1;
    sif.key_in = K1;
    sif.start  = 1'b1;
    tick();
    sif.start = 1'b0;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", sif.busy, 0);
    chk("arst_kv", sif.keys_valid, 0);
    chk("arst_rdkey", sif.rd_key, 0);
    chk("arst_rcon", kg_rcon, 0);
    tick();
    rst = 1'b0;
    rdchk("arst_store1", 4'd1, 0);
    rdchk("arst_store0", 4'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
